stream_encoder: RTL

//  Upstream counterpart of the table-driven stream decoder. Accepts WIDTH_IN-bit

---
 rtl/stream_encoder_pkg.sv | 30 +++
 rtl/stream_encoder_word_fifo.sv | 55 +++++
 rtl/stream_encoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/stream_encoder_pkg.sv
// stream_encoder_pkg: shared helpers and types for the stream encoder.
// Provides the field-width helper, default parameters and flush FSM states.
package stream_encoder_pkg;

  // Number of bits needed to hold the value x (so a code-width field
  // can represent MAX_CODE_LENGTH itself).
  function automatic int log2(input int x);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= x) n = i + 1;
    end
    return n;
  endfunction

  localparam int WIDTH_IN_DEF        = 8;
  localparam int WIDTH_OUT_DEF       = 64;
  localparam int MAX_CODE_LENGTH_DEF = 9;
  localparam int FIFO_DEPTH_DEF      = 4;
  localparam int LOG2_MAX_CODE_LENGTH_DEF =
    log2(MAX_CODE_LENGTH_DEF);

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_DRAIN,
    FL_PAD,
    FL_DONE
  } flush_state_t;

endpackage

// File: rtl/stream_encoder_word_fifo.sv
// encoder_word_fifo: DEPTH x WIDTH register FIFO with occupancy count.
// Ports: clk, rst (sync), wr/wdata, rd, head, count, empty, full.
module encoder_word_fifo
  import stream_encoder_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = WIDTH_OUT_DEF,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;
  assign head  = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) rp <= rp + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= wdata;
  end

endmodule

// File: rtl/stream_encoder.sv
// stream_encoder: table-driven variable-length encoder and bit packer.
// Ports: push/d/full in, flush/flush_done, q/q_push/downstream_full, table_*.
module stream_encoder
  import stream_encoder_pkg::*;
#(
  parameter int WIDTH_IN             = WIDTH_IN_DEF,
  parameter int WIDTH_OUT            = WIDTH_OUT_DEF,
  parameter int MAX_CODE_LENGTH      = MAX_CODE_LENGTH_DEF,
  parameter int LOG2_MAX_CODE_LENGTH = log2(MAX_CODE_LENGTH),
  parameter int FIFO_DEPTH           = FIFO_DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [WIDTH_IN-1:0]             d,
  output logic                            full,
  input  logic                            flush,
  output logic                            flush_done,
  output logic [WIDTH_OUT-1:0]            q,
  output logic                            q_push,
  input  logic                            downstream_full,
  input  logic                            table_push,
  input  logic [WIDTH_IN-1:0]             table_addr,
  input  logic [MAX_CODE_LENGTH-1:0]      table_code,
  input  logic [LOG2_MAX_CODE_LENGTH-1:0] table_code_width
);

  localparam int ACC_W  = WIDTH_OUT + MAX_CODE_LENGTH;
  localparam int FILL_W = log2(ACC_W);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int TBL_N  = 2 ** WIDTH_IN;
  localparam int ML     = MAX_CODE_LENGTH;
  localparam int LW     = LOG2_MAX_CODE_LENGTH;

  logic                s0_valid;
  logic [WIDTH_IN-1:0] s0_sym;
  logic                tw_valid;
  logic [WIDTH_IN-1:0] tw_addr;
  logic [ML-1:0]       tw_code;
  logic [LW-1:0]       tw_width;
  logic [LW-1:0]       w_clamp;
  logic [ML-1:0]       code_mask;

  logic                s1_valid;
  logic [ML-1:0]       s1_code;
  logic [LW-1:0]       s1_width;

  logic [ML-1:0]       code_ram  [TBL_N];
  logic [LW-1:0]       width_ram [TBL_N];

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    ins;
  logic [ACC_W-1:0]    merged;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   fill_d;
  logic [FILL_W-1:0]   sum;

  flush_state_t        state;
  flush_state_t        state_d;

  logic                 fifo_wr;
  logic [WIDTH_OUT-1:0] fifo_wdata;
  logic [WIDTH_OUT-1:0] head;
  logic [CNT_W-1:0]     count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 accept;

  // Two FIFO slots stay free for symbols already in the pipeline.
  assign full = rst
              | (count >= CNT_W'(FIFO_DEPTH - 2))
              | (state != FL_IDLE)
              | table_push
              | tw_valid;

  assign accept = push & ~full;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      tw_valid <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s0_valid <= accept;
      tw_valid <= table_push;
      s1_valid <= s0_valid;
    end
  end

  always_ff @(posedge clk) begin
    s0_sym   <= d;
    tw_addr  <= table_addr;
    tw_code  <= table_code;
    tw_width <= table_code_width;
  end

  // Oversized widths saturate so the accumulator headroom holds.
  always_comb begin
    w_clamp = tw_width;
    if (tw_width > LW'(ML)) w_clamp = LW'(ML);
    code_mask = '0;
    for (int i = 0; i < ML; i++) begin
      code_mask[i] = (i < int'(w_clamp));
    end
  end

  always_ff @(posedge clk) begin
    if (tw_valid) begin
      code_ram[tw_addr]  <= tw_code & code_mask;
      width_ram[tw_addr] <= w_clamp;
    end else if (s0_valid) begin
      s1_code  <= code_ram[s0_sym];
      s1_width <= width_ram[s0_sym];
    end
  end

  // Bits at and above fill are always zero, so OR inserts the code.
  always_comb begin
    acc_d      = acc;
    fill_d     = fill;
    state_d    = state;
    fifo_wr    = 1'b0;
    fifo_wdata = acc[WIDTH_OUT-1:0];
    ins        = ACC_W'(s1_code) << fill;
    merged     = acc | ins;
    sum        = fill + FILL_W'(s1_width);

    unique case (state)
      FL_IDLE: begin
        if (flush) state_d = FL_DRAIN;
      end
      FL_DRAIN: begin
        if (!s0_valid && !s1_valid) state_d = FL_PAD;
      end
      FL_PAD: begin
        if (fill == '0) begin
          state_d = FL_DONE;
        end else if (!fifo_full) begin
          fifo_wr    = 1'b1;
          fifo_wdata = acc[WIDTH_OUT-1:0];
          acc_d      = '0;
          fill_d     = '0;
          state_d    = FL_DONE;
        end
      end
      FL_DONE: begin
        state_d = FL_IDLE;
      end
      default: begin
        state_d = FL_IDLE;
      end
    endcase

    if (s1_valid) begin
      if (sum >= FILL_W'(WIDTH_OUT)) begin
        fifo_wr    = 1'b1;
        fifo_wdata = merged[WIDTH_OUT-1:0];
        acc_d      = merged >> WIDTH_OUT;
        fill_d     = sum - FILL_W'(WIDTH_OUT);
      end else begin
        acc_d  = merged;
        fill_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      fill  <= '0;
      state <= FL_IDLE;
    end else begin
      acc   <= acc_d;
      fill  <= fill_d;
      state <= state_d;
    end
  end

  encoder_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WIDTH_OUT),
    .CW    (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (fifo_wr),
    .wdata (fifo_wdata),
    .rd    (q_push),
    .head  (head),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign q_push     = ~rst & ~fifo_empty & ~downstream_full;
  assign q          = q_push ? head : '0;
  assign flush_done = ~rst & (state == FL_DONE);

endmodule
